// File: rtl/weight_pkg.sv
// weight_pkg: shared widths and FSM encoding for the weight update block.
package weight_pkg;
   localparam int WW_DEF = 8;
   localparam int DW = 4;
   typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_e;
endpackage

// File: rtl/sat_add.sv
// sat_add: WW-bit weight plus sign-extended DW-bit delta; clamps only when WEIGHT_SAT_EN is defined.
module sat_add
   import weight_pkg::*;
#(
   parameter int WW = WW_DEF
) (
   input  logic [WW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [WW-1:0] y_o,
   output logic          sat_o
);
   logic [WW:0] sum;
   assign sum = {a_i[WW-1], a_i} + {{(WW+1-DW){b_i[DW-1]}}, b_i};
`ifdef WEIGHT_SAT_EN
   logic ovf;
   assign ovf   = sum[WW] ^ sum[WW-1];
   assign y_o   = ovf ? {sum[WW], {(WW-1){~sum[WW]}}} : sum[WW-1:0];
   assign sat_o = ovf;
`else
   assign y_o   = sum[WW-1:0];
   assign sat_o = 1'b0;
`endif
endmodule

// File: rtl/weight_update.sv
// weight_update: two-stage pixel weight accumulator with forwarding and a sweeping clear.
// Saturating arithmetic is enabled by defining WEIGHT_SAT_EN.
module weight_update
   import weight_pkg::*;
#(
   parameter int             NPIX   = 16,
   parameter int             WW     = WW_DEF,
   parameter logic [WW-1:0]  W_INIT = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DW-1:0]           dw,
   input  logic                    dw_valid,
   input  logic [$clog2(NPIX)-1:0] addr,
   output logic                    ready,
   input  logic                    clear,
   input  logic [$clog2(NPIX)-1:0] rd_addr,
   output logic [WW-1:0]           rd_data,
   output logic [15:0]             upd_cnt,
   output logic                    sat
);
   localparam int AW = $clog2(NPIX);
   state_e        state_q;
   logic [WW-1:0] w_q [NPIX];
   logic          s1_v_q;
   logic [AW-1:0] s1_addr_q;
   logic [DW-1:0] s1_dw_q;
   logic [WW-1:0] s1_w_q;
   logic [AW-1:0] idx_q;
   logic [15:0]   upd_cnt_q;
   logic          sat_q;
   logic [WW-1:0] rd_data_q;
   logic [WW-1:0] sum;
   logic          sum_sat;
   logic          acc;
   logic [WW-1:0] operand;
   sat_add #(.WW(WW)) u_add (
      .a_i  (s1_w_q),
      .b_i  (s1_dw_q),
      .y_o  (sum),
      .sat_o(sum_sat)
   );
   assign ready   = state_q != CLEAR;
   assign acc     = dw_valid && ready && !clear;
   // the operand is captured at acceptance, so a same-address commit must be forwarded
   assign operand = (s1_v_q && s1_addr_q == addr) ? sum : w_q[addr];
   assign rd_data = rd_data_q;
   assign upd_cnt = upd_cnt_q;
   assign sat     = sat_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         s1_v_q    <= 1'b0;
         s1_addr_q <= '0;
         s1_dw_q   <= '0;
         s1_w_q    <= W_INIT;
         idx_q     <= '0;
         upd_cnt_q <= '0;
         sat_q     <= 1'b0;
         rd_data_q <= W_INIT;
         for (int i = 0; i < NPIX; i++) w_q[i] <= W_INIT;
      end else begin
         rd_data_q <= w_q[rd_addr];
         sat_q     <= s1_v_q && sum_sat;
         s1_v_q    <= acc;
         if (acc) begin
            s1_addr_q <= addr;
            s1_dw_q   <= dw;
            s1_w_q    <= operand;
         end
         if (state_q == CLEAR) begin
            w_q[idx_q] <= W_INIT;
            idx_q      <= idx_q + 1'b1;
            if (idx_q == AW'(NPIX - 1)) begin
               state_q   <= IDLE;
               upd_cnt_q <= '0;
            end
         end else begin
            if (s1_v_q) begin
               w_q[s1_addr_q] <= sum;
               upd_cnt_q      <= upd_cnt_q + 16'd1;
            end
            state_q <= clear ? CLEAR : (acc || s1_v_q) ? RUN : IDLE;
         end
      end
   end
endmodule

// File: doc/weight_update.md
WEIGHT_UPDATE -- requirements
Module: weight_update

Interface
REQ-001 SHALL have parameter NPIX, default 16, number of pixel weights stored (power of two, 4..64).
REQ-002 SHALL have parameter WW, default 8, weight width in bits, two's complement.
REQ-003 SHALL have parameter [WW-1:0] W_INIT, default 0, value loaded into every weight by reset and clear.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port dw  input  4  weight delta from the learning-rule stage, two's complement.
REQ-007 SHALL have port dw_valid  input  1  dw and addr are valid this cycle.
REQ-008 SHALL have port addr  input  $clog2(NPIX)  pixel index that dw applies to.
REQ-009 SHALL have port ready  output  1  block accepts dw_valid this cycle.
REQ-010 SHALL have port clear  input  1  request to reload all weights with W_INIT.
REQ-011 SHALL have port rd_addr  input  $clog2(NPIX)  read index.
REQ-012 SHALL have port rd_data  output  WW  registered weight at rd_addr.
REQ-013 SHALL have port upd_cnt  output  16  count of committed updates, wraps at 16'hFFFF.
REQ-014 SHALL have port sat  output  1  one-cycle pulse when a commit saturated.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, CLEAR; IDLE->RUN on first accepted dw_valid; RUN->IDLE when pipeline empty and no dw_valid.
REQ-016 SHALL accept an update when dw_valid && ready; ready = 1 in IDLE and RUN, 0 in CLEAR.
REQ-017 SHALL use two stages: S1 registers addr and sign-extended dw; S2 computes w[addr]+dw and writes it; commit one cycle after acceptance.
REQ-018 SHALL sustain one accepted update per cycle with no bubbles.
REQ-019 SHALL forward the S2 result into S1 when consecutive updates target the same addr, so back-to-back updates to one weight both take effect.
REQ-020 SHALL treat dw == 0 as a valid update: written, counted, no weight change.
REQ-021 SHALL increment upd_cnt by one per committed update, wrap 16'hFFFF -> 0.
REQ-022 SHALL enter CLEAR on clear==1 in any state, after committing an update already in S2; an update in S1 at that moment is discarded.
REQ-023 SHALL in CLEAR write W_INIT to one index per cycle, 0..NPIX-1, then return to IDLE; clear asserted during CLEAR is ignored; upd_cnt reset to 0 on exit.
REQ-024 SHALL present rd_data one cycle after rd_addr, reflecting writes committed on or before the rd_addr cycle edge.
REQ-025 SHALL treat simultaneous clear and dw_valid as clear only; the dw is not accepted (ready already 1 is ignored for that cycle).

Reset
REQ-026 SHALL on rst asynchronously set state IDLE, all weights W_INIT, pipeline empty, upd_cnt 0, sat 0, rd_data W_INIT, ready 1 after release.
REQ-027 SHALL on rst mid-operation (RUN or CLEAR) abandon any in-flight update or sweep.

Configuration
REQ-028 SHALL, with WEIGHT_SAT_EN defined, clamp sums to [-2^(WW-1), 2^(WW-1)-1] and pulse sat on clamp.
REQ-029 SHALL, without WEIGHT_SAT_EN, wrap sums modulo 2^WW and hold sat at 0.

Structure
REQ-030 SHALL place the FSM state encoding, WW default and DW width (4) in package weight_pkg.
REQ-031 SHALL implement the add/clamp as sub-module sat_add (WW-bit plus sign-extended 4-bit, sat flag out).

Verification
REQ-032 SHALL cover: after reset, rd_addr=5 -> rd_data=0, upd_cnt=0, ready=1.
REQ-033 SHALL cover: dw=4'b0010 at addr 3 -> two cycles later rd_data(3)=2, upd_cnt=1.
REQ-034 SHALL cover: back-to-back dw=4'b0110 then 4'b1110 at addr 7 -> w[7]=6-2=4, upd_cnt=2.
REQ-035 SHALL cover: WEIGHT_SAT_EN, w[0]=126, dw=4'b0100 -> w[0]=127, sat pulses; without macro -> w[0]=-126, sat=0.
REQ-036 SHALL cover: clear in RUN -> ready=0 for NPIX=16 cycles, all weights W_INIT, upd_cnt=0.
REQ-037 SHALL cover: rst asserted mid-CLEAR at index 8 -> all weights W_INIT, state IDLE, ready=1 after release.
